reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file (x0–x31) with per-register rename state (busy flag plus producing ROB tag).
- Sits directly downstream of the reorder buffer.
  - Consumes the ROB commit stream (commit_valid / rd / rdTag / rdVal) and its rollback pulse.
  - Serves the issue/decode stage with two combinational operand lookups and accepts the destination rename at issue.
- Operand lookups return a ready value or the ROB tag to wait on.

Parameters:
- NUM_REGS, 32, architectural registers; index width 5.
- TAG_W, 4, ROB tag width; must match ROB size 16, the ROBRange width in defines.v.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; state holds when low.
- rollback  input  1  ROB misprediction flush pulse.
- commit_valid  input  1  ROB commit strobe.
- commit_rd  input  5  committed destination register.
- commit_rdTag  input  TAG_W  ROB tag of the committing entry.
- commit_rdVal  input  32  committed result.
- issue_valid  input  1  instruction issued this cycle.
- issue_rd  input  5  destination register of the issued instruction.
- issue_tag  input  TAG_W  ROB tag allocated (the ROB's nextTag).
- rs1_idx  input  5  read port 1 index.
- rs1_val  output  32  register value; valid when rs1_busy=0.
- rs1_busy  output  1  operand pending in ROB.
- rs1_tag  output  TAG_W  ROB tag producing rs1.
- rs2_idx / rs2_val / rs2_busy / rs2_tag: same as port 1.

Behaviour:
- **Reset** (rst low, asynchronous): all 32 values = 0, all busy = 0, all tags = 0. Read outputs follow combinationally from the cleared state (val 0, busy 0, tag 0).
- **rdy low**: no state change; reads remain combinational.
- **Commit**, on a rising edge with rdy=1, commit_valid=1, commit_rd≠0:
  - value[commit_rd] <= commit_rdVal.
  - busy[commit_rd] <= 0 only if busy=1 and tag[commit_rd]==commit_rdTag. A newer rename keeps the register busy.
- **Issue**, with rdy=1, issue_valid=1, issue_rd≠0, rollback=0:
  - busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
  - Overrides a same-cycle commit clear on the same register.
  - The value array is untouched.
- **Rollback** (rdy=1, rollback=1):
  - Every busy <= 0; tags are left as-is (don't-care when not busy).
  - Issue in the same cycle is ignored.
  - A same-cycle commit value write still occurs; the committed instruction precedes the branch.
- **x0**: never written, never busy. Reads of index 0 return val 0, busy 0, tag 0 regardless of state.
- **Read ports**: purely combinational, zero latency. Each port evaluates in priority order:
  1. idx==0 → (0, 0, 0).
  2. Else if busy[idx] and commit_valid and commit_rd==idx and commit_rdTag==tag[idx] → bypass: val=commit_rdVal, busy=0, tag=tag[idx].
  3. Else → (value[idx], busy[idx], tag[idx]).
- **Read ordering**: reads reflect the mapping before this cycle's issue, so an instruction with rs==rd reads the prior producer.
- **Bypass gating**: the bypass is not gated by rdy or rollback.
- **Tag wrap**: tags are compared by equality only; ROB guarantees a live tag is unique.
- **Width rules**: no arithmetic; value width fixed at 32.

Decomposition:
- TAG_W/ROBRange and True/False come from the shared defines.v include.
- No sub-module needed. The two read ports are identical combinational logic; write them as one function instantiated twice.

Test Plan:
- **Reset**: drop rst mid-run after writes → all reads of x1..x31 return val 0, busy 0 immediately, without waiting for a clock edge.
- **Issue/commit**: issue rd=5 tag=3; next cycle read x5 → busy 1 tag 3. Commit rd=5 tag=3 val=0xDEADBEEF → same-cycle read gives val 0xDEADBEEF busy 0; after edge, busy 0, value held.
- **Stale commit**: issue rd=7 tag=2, then issue rd=7 tag=4. Commit rd=7 tag=2 val=0x11 → value=0x11, busy stays 1 with tag 4, and the read port does not bypass.
- **Simultaneous**: same edge commit rd=9 tag=1 and issue rd=9 tag=6 (busy tag 1 before) → after edge busy 1 tag 6, value updated.
- **Rollback**: x3, x4 busy; rollback=1 with issue rd=3 tag=8 → after edge all busy 0, x3 not re-renamed.
- **x0 and rdy**: issue/commit to rd=0 with val 0x55 → x0 reads 0, not busy. With rdy=0, issue rd=10 → x10 stays not busy.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and the operand lookup result type for the register file.
package reg_file_pkg;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int TAG_W    = 4;
  localparam int XLEN     = 32;
  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rd_res_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: architectural registers with rename state, ROB commit/rollback and two bypassing read ports.
module reg_file
  import reg_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             commit_valid,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_rdTag,
  input  logic [XLEN-1:0]  commit_rdVal,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [IDX_W-1:0] rs1_idx,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs1_tag,
  input  logic [IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]  rs2_val,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs2_tag
);
  logic [XLEN-1:0]     r_val [NUM_REGS];
  logic [TAG_W-1:0]    r_tag [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  rd_res_t             w_rs1, w_rs2;

  // Rollback wins over issue; the commit value write still lands since it precedes the branch.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_val  <= '{default: '0};
      r_tag  <= '{default: '0};
      r_busy <= '0;
    end else if (rdy) begin
      if (commit_valid && commit_rd != '0) begin
        r_val[commit_rd] <= commit_rdVal;
        if (r_busy[commit_rd] && r_tag[commit_rd] == commit_rdTag) r_busy[commit_rd] <= 1'b0;
      end
      if (rollback) r_busy <= '0;
      else if (issue_valid && issue_rd != '0) begin
        r_busy[issue_rd] <= 1'b1;
        r_tag[issue_rd]  <= issue_tag;
      end
    end

  function automatic rd_res_t lookup(input logic [IDX_W-1:0] idx);
    logic hit;
    hit = r_busy[idx] && commit_valid && commit_rd == idx && commit_rdTag == r_tag[idx];
    return (idx == '0) ? '0 :
           hit ? '{val: commit_rdVal, busy: 1'b0, tag: r_tag[idx]} :
                 '{val: r_val[idx], busy: r_busy[idx], tag: r_tag[idx]};
  endfunction

  always_comb begin
    w_rs1 = lookup(rs1_idx);
    w_rs2 = lookup(rs2_idx);
  end

  assign {rs1_val, rs1_busy, rs1_tag} = w_rs1;
  assign {rs2_val, rs2_busy, rs2_tag} = w_rs2;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors for rename, commit, bypass, rollback, x0, rdy and async reset.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, commit_valid, issue_valid;
  logic [4:0]  commit_rd, issue_rd, rs1_idx, rs2_idx;
  logic [3:0]  commit_rdTag, issue_tag, rs1_tag, rs2_tag;
  logic [31:0] commit_rdVal, rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  int          checks = 0;
  int          errors = 0;

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rdTag(commit_rdTag), .commit_rdVal(commit_rdVal),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1_idx(rs1_idx), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_idx(rs2_idx), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rollback = 1'b0; commit_valid = 1'b0; issue_valid = 1'b0;
    commit_rd = '0; commit_rdTag = '0; commit_rdVal = '0;
    issue_rd = '0; issue_tag = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tg);
    issue_valid = 1'b1; issue_rd = rd; issue_tag = tg;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] v);
    commit_valid = 1'b1; commit_rd = rd; commit_rdTag = tg; commit_rdVal = v;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rs1_idx = 5'd5; rs2_idx = 5'd31;
    idle();
    #3;
    chk("reset_rs1", {rs1_val, rs1_busy, rs1_tag}, 0);
    chk("reset_rs2", {rs2_val, rs2_busy, rs2_tag}, 0);
    @(negedge clk); rst = 1'b1;
    cyc();
    // issue then commit with same-cycle bypass
    issue(5'd5, 4'd3); cyc(); idle();
    rs1_idx = 5'd5; #1;
    chk("issue_x5", {rs1_val, rs1_busy, rs1_tag}, {32'h0, 1'b1, 4'd3});
    commit(5'd5, 4'd3, 32'hDEADBEEF); #1;
    chk("bypass_x5", {rs1_val, rs1_busy, rs1_tag}, {32'hDEADBEEF, 1'b0, 4'd3});
    cyc(); idle(); #1;
    chk("commit_x5", {rs1_val, rs1_busy}, {32'hDEADBEEF, 1'b0});
    // stale commit must not clear a newer rename nor bypass
    issue(5'd7, 4'd2); cyc();
    issue(5'd7, 4'd4); cyc(); idle();
    commit(5'd7, 4'd2, 32'h11); rs2_idx = 5'd7; #1;
    chk("stale_nobyp", {rs2_val, rs2_busy, rs2_tag}, {32'h0, 1'b1, 4'd4});
    cyc(); idle(); #1;
    chk("stale_after", {rs2_val, rs2_busy, rs2_tag}, {32'h11, 1'b1, 4'd4});
    // simultaneous commit and re-issue on the same register
    issue(5'd9, 4'd1); cyc(); idle();
    commit(5'd9, 4'd1, 32'h99); issue(5'd9, 4'd6); rs1_idx = 5'd9; #1;
    chk("simul_read", {rs1_val, rs1_busy, rs1_tag}, {32'h99, 1'b0, 4'd1});
    cyc(); idle(); #1;
    chk("simul_after", {rs1_val, rs1_busy, rs1_tag}, {32'h99, 1'b1, 4'd6});
    // rollback with ignored issue and a surviving commit write
    issue(5'd3, 4'd5); cyc();
    issue(5'd4, 4'd7); cyc(); idle();
    rollback = 1'b1; issue(5'd3, 4'd8); commit(5'd4, 4'd7, 32'h44);
    rs1_idx = 5'd3; rs2_idx = 5'd4; #1;
    chk("rb_pre_x3", {rs1_val, rs1_busy, rs1_tag}, {32'h0, 1'b1, 4'd5});
    chk("rb_byp_x4", {rs2_val, rs2_busy, rs2_tag}, {32'h44, 1'b0, 4'd7});
    cyc(); idle(); #1;
    chk("rb_x3", {rs1_val, rs1_busy, rs1_tag}, {32'h0, 1'b0, 4'd5});
    chk("rb_x4", {rs2_val, rs2_busy}, {32'h44, 1'b0});
    rs1_idx = 5'd7; rs2_idx = 5'd9; #1;
    chk("rb_x7", rs1_busy, 1'b0);
    chk("rb_x9", rs2_busy, 1'b0);
    // x0 is never written nor renamed
    issue(5'd0, 4'd2); commit(5'd0, 4'd2, 32'h55); rs1_idx = 5'd0; #1;
    chk("x0_pre", {rs1_val, rs1_busy, rs1_tag}, 0);
    cyc(); idle(); #1;
    chk("x0_post", {rs1_val, rs1_busy, rs1_tag}, 0);
    // rdy low freezes state
    rdy = 1'b0; issue(5'd10, 4'd1); commit(5'd5, 4'd3, 32'h77); cyc();
    rdy = 1'b1; idle(); rs1_idx = 5'd10; rs2_idx = 5'd5; #1;
    chk("rdy_x10", rs1_busy, 1'b0);
    chk("rdy_x5", rs2_val, 32'hDEADBEEF);
    // asynchronous reset mid-cycle clears everything immediately
    issue(5'd12, 4'd9); cyc(); idle();
    rs1_idx = 5'd12; #1;
    chk("pre_rst_x12", {rs1_busy, rs1_tag}, {1'b1, 4'd9});
    rst = 1'b0; #1;
    for (int i = 1; i < 32; i++) begin
      rs1_idx = 5'(i); #0.1;
      chk($sformatf("rst_x%0d", i), {rs1_val, rs1_busy, rs1_tag}, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
